uart_tx_fifo_reader: RTL and testbench
======================================

// Module: uart_tx_fifo_reader
// PURPOSE
//   Read side of the 4-deep, 8-bit TX byte FIFO. Pops one byte whenever the FIFO is non-empty
//   and serialises it onto the UART line as 8N1, LSB first.
//   Sits between the TX FIFO pop port and the top-level tx pin. Sensor and stopwatch report
//   formatters push into the same FIFO.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        9600         line rate, bit/s
//   OVERSAMPLE  16           baud ticks per bit; DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated, must be >= 2
// PORTS
//   clk            in   1  system clock, rising edge
//   rst            in   1  reset; asynchronous, active-high
//   fifo_empty     in   1  FIFO empty flag
//   fifo_pop_data  in   8  FIFO head byte; fall-through, valid whenever fifo_empty=0
//   fifo_pop       out  1  one-cycle pop strobe to the FIFO
//   tx             out  1  serial line, idle high, registered
//   tx_busy        out  1  high from the start bit through the end of the stop bit
//   tx_done        out  1  one-cycle pulse on the last clock of the stop bit
// BEHAVIOUR
//   Reset values: tx=1, fifo_pop=0, tx_busy=0, tx_done=0, state=IDLE, bit_idx=0, tick_cnt=0, baud divider cleared.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE:
//   - fifo_pop = ~fifo_empty, combinational, asserted in IDLE only.
//   - On the edge where fifo_pop=1: shift_reg <= fifo_pop_data, tx <= 0, state <= START.
//   - Effect: exactly one pop per frame, and tx falls on the clock after pop.
//   - The baud divider is held cleared in IDLE, so every bit lasts exactly OVERSAMPLE*DIV clocks.
//   START: tx=0 for OVERSAMPLE ticks, then DATA.
//   DATA:
//   - tx = shift_reg[0] for OVERSAMPLE ticks per bit; shift right after each bit.
//   - bit_idx counts 0..7; after bit 7 go to STOP.
//   STOP:
//   - tx=1 for OVERSAMPLE ticks.
//   - On the final tick: tx_done=1 for one clock, tx_busy deasserts, state <= IDLE.
//   Back-to-back frames: with the FIFO non-empty at STOP exit, the next pop happens on the first
//   IDLE clock. Frames are then separated by exactly one idle-high clock beyond the stop bit.
//   fifo_empty and fifo_pop_data are ignored outside IDLE. A push during a frame does not disturb it.
//   Empty FIFO: stays in IDLE with tx=1 indefinitely. fifo_pop is never asserted while fifo_empty=1.
//   Reset mid-frame:
//   - tx goes to 1 immediately (asynchronous).
//   - The in-flight byte is dropped; it was already popped.
//   - After rst is released, the next non-empty FIFO byte starts a fresh frame.
//   Counters: tick_cnt has width $clog2(OVERSAMPLE) and wraps at OVERSAMPLE-1; bit_idx is 3 bits.
//   Widths are sized so no truncation occurs at the default parameter values.
// STRUCTURE
//   Shared package uart_pkg:
//   - state encoding localparams: ST_IDLE, ST_START, ST_DATA, ST_STOP;
//   - DATA_BITS=8 and default OVERSAMPLE=16, shared with the future UART RX.
//   Sub-module uart_baud_tick:
//   - parameter DIV; inputs clk, rst, clr; output tick, a one-cycle pulse every DIV clocks;
//   - count restarts from 0 while clr=1.
//   The FSM, shift register and counters live in this module.
// TESTING  (bench uses CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, bit=160 clk, frame=1600 clk;
//          FIFO model = 4-deep fall-through FIFO)
//   1 Reset: assert rst mid-simulation -> tx=1, fifo_pop=0, tx_busy=0, tx_done=0 in the same cycle.
//   2 Single byte 0xA5:
//     - exactly one fifo_pop pulse, then tx low for 160 clk;
//     - then bits 1,0,1,0,0,1,0,1 for 160 clk each;
//     - then tx high for 160 clk; tx_done pulses once; tx_busy high for 1600 clk.
//   3 Burst: preload 0x01,0x02,0x03,0x04 until full=1 ->
//     - 4 pops and 4 decoded frames in order;
//     - 1 idle clock between frames; no 5th pop once fifo_empty=1.
//   4 Idle: fifo_empty=1 for 5000 clk -> fifo_pop never asserted, tx constantly 1.
//   5 Reset during DATA bit 3 of 0x3C, with 0x77 still queued:
//     - tx=1 at once;
//     - after release the next frame decodes 0x77; 0x3C is never completed.
//   6 Boundary bytes 0x00 then 0xFF: line low for 1440 clk then high in frame 1;
//     frame 2 shows 160 clk low (start) then 1440 clk high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default oversampling and the state encoding
// used by the TX path (and later by the RX path).
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Clocks per baud tick; truncating division, caller guarantees a result >= 2.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks; held at zero while clr=1
// so the first tick after clr drops arrives exactly DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    tick     = (cnt_reg == CW'(DIV - 1));
    cnt_next = cnt_reg + 1'b1;
    if (clr || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Drains the TX byte FIFO: pops one byte when it is non-empty and sends it as an 8N1 frame,
// LSB first, on the registered tx line.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_pop_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV    = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic                 tx_reg, tx_next;
  logic                 baud_tick;
  logic                 bit_end;

  // Divider is held cleared in IDLE so every frame starts on a fresh bit boundary.
  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == ST_IDLE),
    .tick (baud_tick)
  );

  assign bit_end = baud_tick && (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1));
  assign tx      = tx_reg;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    tick_cnt_next = tick_cnt_reg;
    tx_next       = tx_reg;
    fifo_pop      = 1'b0;
    tx_done       = 1'b0;
    tx_busy       = (state_reg != ST_IDLE);

    if (baud_tick && (state_reg != ST_IDLE)) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        // Gated by rst so nothing is popped while the block is held in reset.
        fifo_pop = ~fifo_empty & ~rst;
        if (fifo_pop) begin
          shift_next    = fifo_pop_data;
          bit_idx_next  = '0;
          tick_cnt_next = '0;
          tx_next       = 1'b0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == BIT_W'(DATA_BITS - 1)) begin
            tx_next    = 1'b1;
            state_next = ST_STOP;
          end else begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          tx_done    = 1'b1;
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      tick_cnt_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      tick_cnt_reg <= tick_cnt_next;
      tx_reg       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: a 4-deep fall-through FIFO model feeds the DUT, a cycle-accurate
// frame monitor decodes tx and compares each frame against the byte scoreboard.
module tb_uart_tx_fifo_reader;

  localparam int BIT_CLK   = 160;
  localparam int FRAME_CLK = 1600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_pop_data;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  // FIFO model
  logic [7:0] mem [4];
  logic [1:0] wr_ptr = 2'd0;
  logic [1:0] rd_ptr = 2'd0;
  logic [2:0] count  = 3'd0;
  logic       push_req  = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ok, pop_ok;

  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int frames_ok = 0;
  int frames_aborted = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_reader #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_pop_data (fifo_pop_data),
    .fifo_pop      (fifo_pop),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  assign fifo_empty    = (count == 3'd0);
  assign fifo_pop_data = mem[rd_ptr];
  assign push_ok       = push_req && (count != 3'd4);
  assign pop_ok        = fifo_pop && (count != 3'd0);

  always @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 2'd1;
    end
    if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
    count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  // Frame monitor: every pop starts a frame whose tx waveform is checked clock by clock.
  initial begin : monitor
    logic [7:0] exp_b;
    logic [7:0] dec_b;
    logic       exp_bit;
    int wave_err, busy_err, pop_err, done_cnt, done_at, bi;
    bit aborted, just_finished;
    just_finished = 0;
    forever begin
      @(negedge clk);
      if (just_finished && !rst) begin
        just_finished = 0;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap: tx=%b tx_busy=%b, required tx=1 tx_busy=0", tx, tx_busy);
        end
        checks++;
        if (fifo_pop !== !fifo_empty) begin
          errors++;
          $display("FAIL back_to_back_pop: fifo_pop=%b, required %b", fifo_pop, !fifo_empty);
        end
      end
      if (!rst && fifo_pop === 1'b1) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: popped 0x%02h, required no pop", fifo_pop_data);
          exp_b = fifo_pop_data;
        end else begin
          exp_b = exp_q.pop_front();
        end
        aborted = 0; wave_err = 0; busy_err = 0; pop_err = 0;
        done_cnt = 0; done_at = -1; dec_b = 8'h00;
        for (int k = 0; k < FRAME_CLK; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          bi = (k - BIT_CLK) / BIT_CLK;
          if (k < BIT_CLK) exp_bit = 1'b0;
          else if (k < 9 * BIT_CLK) exp_bit = exp_b[bi[2:0]];
          else exp_bit = 1'b1;
          if (tx !== exp_bit) wave_err++;
          if (tx_busy !== 1'b1) busy_err++;
          if (fifo_pop !== 1'b0) pop_err++;
          if (tx_done === 1'b1) begin
            done_cnt++;
            done_at = k;
          end
          if (k >= BIT_CLK && k < 9 * BIT_CLK && (k % BIT_CLK) == BIT_CLK / 2)
            dec_b[bi[2:0]] = tx;
        end
        if (aborted) begin
          frames_aborted++;
          $display("frame aborted by reset: byte 0x%02h", exp_b);
        end else begin
          frames_ok++;
          dec_q.push_back(dec_b);
          $display("frame %0d: expected 0x%02h decoded 0x%02h", frames_ok, exp_b, dec_b);
          checks++;
          if (dec_b !== exp_b) begin
            errors++;
            $display("FAIL frame_byte: decoded 0x%02h, required 0x%02h", dec_b, exp_b);
          end
          checks++;
          if (wave_err != 0) begin
            errors++;
            $display("FAIL frame_waveform: %0d wrong tx clocks, required 0 (byte 0x%02h)", wave_err, exp_b);
          end
          checks++;
          if (busy_err != 0 || pop_err != 0) begin
            errors++;
            $display("FAIL frame_busy_pop: busy low %0d clk, pops %0d, required 0 and 0", busy_err, pop_err);
          end
          checks++;
          if (done_cnt != 1 || done_at != FRAME_CLK - 1) begin
            errors++;
            $display("FAIL tx_done_pulse: %0d pulses at clk %0d, required 1 at clk %0d",
                     done_cnt, done_at, FRAME_CLK - 1);
          end
          just_finished = 1;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (count == 3'd4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: FIFO still full after %0d clk, required space", n);
    end
    push_req  = 1'b1;
    push_data = b;
    exp_q.push_back(b);
    $display("push 0x%02h", b);
    @(negedge clk);
    push_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_ok < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_ok < target) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: %0d frames, required %0d within %0d clk", frames_ok, target, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push_byte(8'hA5);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b, required 1", tx); end
    checks++;
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: fifo_pop=%b, required 0", fifo_pop); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: tx_busy=%b, required 0", tx_busy); end
    checks++;
    if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: tx_done=%b, required 0", tx_done); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    wait_frames(1, FRAME_CLK + 200);
    checks++;
    if (pops != 1) begin errors++; $display("FAIL single_pops: %0d pops, required 1", pops); end
    repeat (20) @(negedge clk);
    checks++;
    if (pops != 1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_after: pops=%0d tx=%b, required pops=1 tx=1", pops, tx);
    end
  endtask

  task automatic test_back_to_back();
    int base_f, base_p;
    logic [7:0] want;
    base_f = frames_ok;
    base_p = pops;
    @(negedge clk);
    #3 rst = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    checks++;
    if (count !== 3'd4 || pops != base_p) begin
      errors++;
      $display("FAIL burst_preload: fifo count %0d pops %0d, required 4 and %0d", count, pops, base_p);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frames(base_f + 4, 4 * (FRAME_CLK + 1) + 200);
    repeat (2000) @(negedge clk);
    checks++;
    if (pops != base_p + 4) begin
      errors++;
      $display("FAIL burst_pops: %0d pops, required %0d", pops - base_p, 4);
    end
    for (int i = 0; i < 4; i++) begin
      want = 8'(i + 1);
      checks++;
      if (dec_q.size() < base_f + 4 || dec_q[base_f + i] !== want) begin
        errors++;
        $display("FAIL burst_order: frame %0d wrong, required 0x%02h", i, want);
      end
    end
  endtask

  task automatic test_idle();
    int pop_seen, tx_low;
    pop_seen = 0;
    tx_low = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fifo_pop !== 1'b0) pop_seen++;
      if (tx !== 1'b1) tx_low++;
    end
    checks++;
    if (pop_seen != 0) begin errors++; $display("FAIL idle_pop: %0d pop clocks, required 0", pop_seen); end
    checks++;
    if (tx_low != 0) begin errors++; $display("FAIL idle_tx: %0d clocks not high, required 0", tx_low); end
  endtask

  task automatic test_reset_mid_frame();
    int base_f, base_a, base_p, n;
    base_f = frames_ok;
    base_a = frames_aborted;
    base_p = pops;
    push_byte(8'h3C);
    n = 0;
    while (pops == base_p && n < 50) begin
      @(negedge clk);
      n++;
    end
    push_byte(8'h77);
    repeat (4 * BIT_CLK + BIT_CLK / 2 - 2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || fifo_pop !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: tx=%b pop=%b busy=%b done=%b, required 1 0 0 0",
               tx, fifo_pop, tx_busy, tx_done);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frames(base_f + 1, FRAME_CLK + 200);
    checks++;
    if (frames_aborted != base_a + 1) begin
      errors++;
      $display("FAIL midreset_abort: %0d aborted, required 1", frames_aborted - base_a);
    end
    checks++;
    if (dec_q.size() != base_f + 1 || dec_q[dec_q.size() - 1] !== 8'h77) begin
      errors++;
      $display("FAIL midreset_next: %0d frames, last 0x%02h, required %0d frames ending 0x77",
               dec_q.size(), dec_q[dec_q.size() - 1], base_f + 1);
    end
    checks++;
    if (pops != base_p + 2) begin errors++; $display("FAIL midreset_pops: %0d, required 2", pops - base_p); end
  endtask

  task automatic test_boundary();
    int base_f;
    base_f = frames_ok;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(base_f + 2, 2 * (FRAME_CLK + 1) + 200);
    checks++;
    if (dec_q.size() != base_f + 2 || dec_q[base_f] !== 8'h00 || dec_q[base_f + 1] !== 8'hFF) begin
      errors++;
      $display("FAIL boundary_bytes: %0d frames, required 0x00 then 0xFF", dec_q.size() - base_f);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_idle();
    test_reset_mid_frame();
    test_boundary();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes never sent, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 clk, required completion");
    $fatal(1, "watchdog");
  end

endmodule
